race_stats: RTL and testbench

- Live statistics engine for the race.
- Keeps the elapsed race time in tenths of a second.
- Periodically, and once more on race finish, computes words-per-minute and accuracy from the running word and character tallies of the typing/count stage.
- Sits downstream of the typing/count stage and feeds the wpm/acc fields of the display stage. Uses one shared sequential divider.

---
 rtl/race_pkg.sv | 47 ++++
 rtl/seq_divider.sv | 52 +++++
 rtl/race_stats.sv | 193 +++++++++++++++++++
 tb/tb_race_stats.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared encodings, widths and scaling constants for the race statistics block.
package race_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned WORDS_W    = 7;
  localparam int unsigned CHARS_W    = 10;
  localparam int unsigned ELAPSED_W  = 11;
  localparam int unsigned DIVIDEND_W = 17;
  localparam int unsigned DIVISOR_W  = 11;
  localparam int unsigned WPM_W      = 8;
  localparam int unsigned ACC_W      = 7;
  localparam int unsigned DIV_CYCLES = DIVIDEND_W;

  localparam int unsigned WPM_SCALE = 600;
  localparam int unsigned ACC_SCALE = 100;
  localparam int unsigned WPM_MAX   = 255;
  localparam int unsigned ACC_MAX   = 100;

  typedef enum logic [1:0] {
    GS_SELECT    = 2'd0,
    GS_COUNTDOWN = 2'd1,
    GS_INGAME    = 2'd2,
    GS_FINISH    = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_WPM = 2'd1,
    ST_DIV_ACC = 2'd2,
    ST_DONE    = 2'd3
  } stats_state_e;

  // Operand pair handed to the shared divider.
  typedef struct packed {
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
  } div_op_t;

  // Clamp a quotient to lim; a zero divisor forces the result to 0.
  function automatic logic [DIVIDEND_W-1:0] sat_quot(input logic [DIVIDEND_W-1:0] q,
                                                     input logic [DIVIDEND_W-1:0] lim,
                                                     input logic              zero_div);
    if (zero_div) return '0;
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; start overrides any op in flight.
module seq_divider
  import race_pkg::*;
(
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done_c,
  output logic [DIVIDEND_W-1:0] quot_c
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);
  localparam int unsigned REM_W = DIVISOR_W + 1;

  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  rem_d;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [REM_W-1:0]      trial;
  logic                  fits;

  // Dividend bits shift out of quo_q's MSB while quotient bits shift in at the LSB.
  always_comb begin
    trial  = {rem_q, quo_q[DIVIDEND_W-1]};
    fits   = (trial >= REM_W'(dvs_q));
    rem_d  = fits ? DIVISOR_W'(trial - REM_W'(dvs_q)) : trial[DIVISOR_W-1:0];
    quot_c = {quo_q[DIVIDEND_W-2:0], fits};
    done_c = (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      dvs_q <= divisor;
      rem_q <= '0;
      quo_q <= dividend;
      cnt_q <= CNT_W'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      rem_q <= rem_d;
      quo_q <= quot_c;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/race_stats.sv
// Race timekeeping plus periodic/finish WPM and accuracy computation on one shared divider.
module race_stats
  import race_pkg::*;
#(
  parameter int unsigned TICKS_PER_DS = 100,
  parameter int unsigned UPDATE_DS    = 10,
  parameter int unsigned ELAPSED_MAX  = 1800
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic [STATE_W-1:0]   state,
  input  logic [WORDS_W-1:0]   words_ok,
  input  logic [CHARS_W-1:0]   chars_ok,
  input  logic [CHARS_W-1:0]   chars_typed,
  output logic [ELAPSED_W-1:0] elapsed_ds,
  output logic [WPM_W-1:0]     wpm,
  output logic [ACC_W-1:0]     acc,
  output logic                 stats_valid,
  output logic                 busy
);

  localparam int unsigned PRE_W = (TICKS_PER_DS > 1) ? $clog2(TICKS_PER_DS) : 1;
  localparam int unsigned UPD_W = (UPDATE_DS > 1) ? $clog2(UPDATE_DS) : 1;

  game_state_e           gs;
  game_state_e           prev_q;
  stats_state_e          fsm_q;
  stats_state_e          fsm_d;
  logic [PRE_W-1:0]      presc_q;
  logic [UPD_W-1:0]      upd_q;
  logic                  req_tick_q;
  logic                  pending_q;
  logic                  zero_a_q;
  div_op_t               op_a_c;
  div_op_t               op_b_c;
  div_op_t               op_b_q;
  div_op_t               div_op_c;
  logic [DIVIDEND_W-1:0] quot_a_q;
  logic [DIVIDEND_W-1:0] quot_b_q;

  logic                  select_c;
  logic                  ingame_c;
  logic                  wrap_c;
  logic                  sat_c;
  logic                  req_c;
  logic                  launch_c;
  logic                  start_c;
  logic                  latch_a_c;
  logic                  latch_b_c;
  logic                  write_c;
  logic                  pend_set_c;
  logic                  div_done_c;
  logic [DIVIDEND_W-1:0] div_quot_c;

  always_comb begin
    gs       = game_state_e'(state);
    select_c = (gs == GS_SELECT);
    ingame_c = (gs == GS_INGAME);
    wrap_c   = ingame_c && (presc_q == PRE_W'(TICKS_PER_DS - 1));
    sat_c    = (elapsed_ds >= ELAPSED_W'(ELAPSED_MAX));
    req_c    = req_tick_q || ((gs == GS_FINISH) && (prev_q != GS_FINISH));
  end

  // Prescaler and elapsed time; the update counter tracks elapsed_ds modulo UPDATE_DS.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      upd_q      <= '0;
      elapsed_ds <= '0;
      req_tick_q <= 1'b0;
      prev_q     <= GS_SELECT;
    end else begin
      prev_q     <= gs;
      req_tick_q <= 1'b0;
      if (select_c) begin
        presc_q    <= '0;
        upd_q      <= '0;
        elapsed_ds <= '0;
      end else if (ingame_c) begin
        presc_q <= wrap_c ? '0 : presc_q + PRE_W'(1);
        if (wrap_c && !sat_c) begin
          elapsed_ds <= elapsed_ds + ELAPSED_W'(1);
          upd_q      <= (upd_q == UPD_W'(UPDATE_DS - 1)) ? '0 : upd_q + UPD_W'(1);
          req_tick_q <= (upd_q == UPD_W'(UPDATE_DS - 1));
        end
      end
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    if (select_c) begin
      fsm_d = ST_IDLE;
    end else begin
      case (fsm_q)
        ST_IDLE:    if (req_c) fsm_d = ST_DIV_WPM;
        ST_DIV_WPM: if (div_done_c) fsm_d = ST_DIV_ACC;
        ST_DIV_ACC: if (div_done_c) fsm_d = ST_DONE;
        ST_DONE:    fsm_d = (pending_q || req_c) ? ST_DIV_WPM : ST_IDLE;
        default:    fsm_d = ST_IDLE;
      endcase
    end
  end

  // A pending or fresh request relaunches straight from DONE without passing through IDLE.
  always_comb begin
    launch_c   = 1'b0;
    latch_a_c  = 1'b0;
    latch_b_c  = 1'b0;
    write_c    = 1'b0;
    pend_set_c = 1'b0;
    if (!select_c) begin
      case (fsm_q)
        ST_IDLE:    launch_c = req_c;
        ST_DIV_WPM: begin
          latch_a_c  = div_done_c;
          pend_set_c = req_c;
        end
        ST_DIV_ACC: begin
          latch_b_c  = div_done_c;
          pend_set_c = req_c;
        end
        ST_DONE: begin
          write_c  = 1'b1;
          launch_c = pending_q || req_c;
        end
        default: ;
      endcase
    end
    start_c = launch_c || latch_a_c;
  end

  always_comb begin
    op_a_c.dividend = DIVIDEND_W'(words_ok) * DIVIDEND_W'(WPM_SCALE);
    op_a_c.divisor  = DIVISOR_W'(elapsed_ds);
    op_b_c.dividend = DIVIDEND_W'(chars_ok) * DIVIDEND_W'(ACC_SCALE);
    op_b_c.divisor  = DIVISOR_W'(chars_typed);
    div_op_c        = latch_a_c ? op_b_q : op_a_c;
  end

  seq_divider u_div (
    .clk_div  (clk_div),
    .rst      (rst),
    .start    (start_c),
    .dividend (div_op_c.dividend),
    .divisor  (div_op_c.divisor),
    .done_c   (div_done_c),
    .quot_c   (div_quot_c)
  );

  // Snapshots, quotient latches and the result write-back.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      pending_q   <= 1'b0;
      busy        <= 1'b0;
      zero_a_q    <= 1'b0;
      op_b_q      <= '0;
      quot_a_q    <= '0;
      quot_b_q    <= '0;
      wpm         <= '0;
      acc         <= '0;
      stats_valid <= 1'b0;
    end else begin
      busy <= (fsm_d != ST_IDLE);
      if (select_c) begin
        pending_q   <= 1'b0;
        wpm         <= '0;
        acc         <= '0;
        stats_valid <= 1'b0;
      end else begin
        if (launch_c)        pending_q <= 1'b0;
        else if (pend_set_c) pending_q <= 1'b1;
        if (write_c) begin
          wpm <= WPM_W'(sat_quot(quot_a_q, DIVIDEND_W'(WPM_MAX), zero_a_q));
          acc <= ACC_W'(sat_quot(quot_b_q, DIVIDEND_W'(ACC_MAX), op_b_q.divisor == '0));
          stats_valid <= 1'b1;
        end
      end
      if (launch_c) begin
        zero_a_q <= (elapsed_ds == '0);
        op_b_q   <= op_b_c;
      end
      if (latch_a_c) quot_a_q <= div_quot_c;
      if (latch_b_c) quot_b_q <= div_quot_c;
    end
  end

endmodule

// File: tb/tb_race_stats.sv
// Randomised and directed bench for race_stats against a job-level behavioural model.
module tb_race_stats;

  localparam int unsigned T    = 2;
  localparam int unsigned UPD  = 10;
  localparam int unsigned EMAX = 1800;

  logic        clk_div = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [6:0]  words_ok;
  logic [9:0]  chars_ok;
  logic [9:0]  chars_typed;
  logic [10:0] elapsed_ds;
  logic [7:0]  wpm;
  logic [6:0]  acc;
  logic        stats_valid;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_div = ~clk_div;

  race_stats #(.TICKS_PER_DS(T), .UPDATE_DS(UPD), .ELAPSED_MAX(EMAX)) dut (
    .clk_div     (clk_div),
    .rst         (rst),
    .state       (state),
    .words_ok    (words_ok),
    .chars_ok    (chars_ok),
    .chars_typed (chars_typed),
    .elapsed_ds  (elapsed_ds),
    .wpm         (wpm),
    .acc         (acc),
    .stats_valid (stats_valid),
    .busy        (busy)
  );

  // Model: elapsed derived from total INGAME cycles; a job is a launch snapshot plus an age.
  int m_cyc, m_elapsed, m_wpm, m_acc, m_age, m_prev;
  int s_a, s_ea, s_b, s_ct;
  bit m_valid, m_busy, m_pend, m_req_tick;

  task automatic model_clear();
    m_cyc = 0; m_elapsed = 0; m_wpm = 0; m_acc = 0; m_age = 0;
    m_valid = 0; m_busy = 0; m_pend = 0; m_req_tick = 0;
  endtask

  task automatic model_update();
    int old_e;
    bit req, new_tick, launch;
    if (rst) begin
      model_clear();
      m_prev = 0;
      return;
    end
    if (state == 2'd0) begin
      model_clear();
      m_prev = 0;
      return;
    end
    req      = m_req_tick || (state == 2'd3 && m_prev != 3);
    old_e    = m_elapsed;
    new_tick = 0;
    if (state == 2'd2) begin
      m_cyc++;
      m_elapsed = (m_cyc / T > EMAX) ? EMAX : m_cyc / T;
      new_tick  = (m_elapsed != old_e) && (m_elapsed % UPD == 0);
    end
    launch = 0;
    if (!m_busy) begin
      launch = req;
    end else begin
      m_age++;
      if (m_age == 35) begin
        m_wpm   = (s_ea == 0) ? 0 : ((s_a / s_ea > 255) ? 255 : s_a / s_ea);
        m_acc   = (s_ct == 0) ? 0 : ((s_b / s_ct > 100) ? 100 : s_b / s_ct);
        m_valid = 1;
        m_busy  = 0;
        launch  = m_pend || req;
        m_pend  = 0;
      end else if (req) begin
        m_pend = 1;
      end
    end
    if (launch) begin
      s_a    = int'(words_ok) * 600;
      s_ea   = old_e;
      s_b    = int'(chars_ok) * 100;
      s_ct   = int'(chars_typed);
      m_busy = 1;
      m_age  = 0;
    end
    m_req_tick = new_tick;
    m_prev     = int'(state);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    cmp("elapsed_ds",  32'(elapsed_ds),  32'(m_elapsed));
    cmp("wpm",         32'(wpm),         32'(m_wpm));
    cmp("acc",         32'(acc),         32'(m_acc));
    cmp("stats_valid", 32'(stats_valid), 32'(m_valid));
    cmp("busy",        32'(busy),        32'(m_busy));
  endtask

  // Advance n clock edges; model and per-cycle compare run at each edge, return at negedge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_div);
      model_update();
      #1;
      compare_all();
      @(negedge clk_div);
    end
  endtask

  task automatic set_in(input logic [1:0] st, input logic [6:0] w,
                        input logic [9:0] co, input logic [9:0] ct);
    state = st; words_ok = w; chars_ok = co; chars_typed = ct;
  endtask

  initial begin
    rst = 1'b1;
    set_in(2'd0, 7'd0, 10'd0, 10'd0);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    cmp("rst_elapsed", 32'(elapsed_ds), 32'd0);
    cmp("rst_wpm", 32'(wpm), 32'd0);
    cmp("rst_acc", 32'(acc), 32'd0);
    cmp("rst_valid", 32'(stats_valid), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);

    // Periodic launch at elapsed 10, wpm clamps 300 -> 255.
    set_in(2'd2, 7'd5, 10'd24, 10'd30);
    cyc(20);
    cmp("p1_elapsed10", 32'(elapsed_ds), 32'd10);
    cmp("p1_busy_pre", 32'(busy), 32'd0);
    cyc(1);
    cmp("p1_busy_post", 32'(busy), 32'd1);
    state = 2'd1;
    cyc(35);
    cmp("p1_wpm_clamp", 32'(wpm), 32'd255);
    cmp("p1_acc", 32'(acc), 32'd80);
    cmp("p1_valid", 32'(stats_valid), 32'd1);
    cmp("p1_busy_done", 32'(busy), 32'd0);

    state = 2'd0;
    cyc(2);
    cmp("sel_valid", 32'(stats_valid), 32'd0);
    set_in(2'd2, 7'd2, 10'd24, 10'd30);
    cyc(21);
    state = 2'd1;
    cyc(35);
    cmp("p2_wpm", 32'(wpm), 32'd120);
    cmp("p2_acc", 32'(acc), 32'd80);
    cmp("p2_valid", 32'(stats_valid), 32'd1);

    // FINISH launches, then SELECT aborts in the ACC division.
    state = 2'd3;
    cyc(1);
    cmp("ab_busy", 32'(busy), 32'd1);
    cyc(24);
    state = 2'd0;
    cyc(1);
    cmp("ab_busy0", 32'(busy), 32'd0);
    cmp("ab_wpm0", 32'(wpm), 32'd0);
    cmp("ab_acc0", 32'(acc), 32'd0);
    cmp("ab_valid0", 32'(stats_valid), 32'd0);
    cmp("ab_elapsed0", 32'(elapsed_ds), 32'd0);
    cyc(40);
    cmp("ab_no_write", 32'(stats_valid), 32'd0);

    // FINISH at elapsed 7 with zero typed chars.
    set_in(2'd2, 7'd3, 10'd0, 10'd0);
    cyc(14);
    cmp("f7_elapsed", 32'(elapsed_ds), 32'd7);
    state = 2'd3;
    cyc(1);
    cmp("f7_busy", 32'(busy), 32'd1);
    cyc(35);
    cmp("f7_wpm", 32'(wpm), 32'd255);
    cmp("f7_acc", 32'(acc), 32'd0);
    cmp("f7_elapsed_frz", 32'(elapsed_ds), 32'd7);

    // FINISH while DIV_WPM busy: pending relaunch on the DONE edge.
    state = 2'd0;
    cyc(2);
    set_in(2'd2, 7'd1, 10'd50, 10'd100);
    cyc(25);
    set_in(2'd3, 7'd4, 10'd90, 10'd100);
    cyc(31);
    cmp("pd_wpm1", 32'(wpm), 32'd60);
    cmp("pd_acc1", 32'(acc), 32'd50);
    cmp("pd_busy_chain", 32'(busy), 32'd1);
    cyc(35);
    cmp("pd_wpm2", 32'(wpm), 32'd200);
    cmp("pd_acc2", 32'(acc), 32'd90);
    cmp("pd_busy_end", 32'(busy), 32'd0);
    cmp("pd_elapsed", 32'(elapsed_ds), 32'd12);

    // Saturation of elapsed_ds.
    state = 2'd0;
    cyc(2);
    set_in(2'd2, 7'd33, 10'd40, 10'd40);
    cyc(2 * 1800 + 50);
    cmp("sat_elapsed", 32'(elapsed_ds), 32'd1800);
    state = 2'd3;
    cyc(80);
    cmp("sat_acc", 32'(acc), 32'd100);
    cmp("sat_wpm", 32'(wpm), 32'd11);
    cmp("sat_busy", 32'(busy), 32'd0);

    // Random segments, including mid-operation resets.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      state = 2'd0;
      else if (r == 1) state = 2'd1;
      else if (r < 8)  state = 2'd2;
      else             state = 2'd3;
      words_ok    = 7'($urandom_range(0, 127));
      chars_ok    = 10'($urandom_range(0, 1023));
      chars_typed = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc(int'($urandom_range(1, 60)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
